// File: rtl/ysyx_22040632_ifu.sv
// ysyx_22040632_ifu: instruction fetch unit.
// Owns the PC and keeps at most one word fetch in flight. It feeds the
// fetch/decode register {pc2id, inst2id}. A one-entry skid buffer catches
// a response that lands while decode is stalled. On a redirect, the DROP
// state waits out a stale in-flight response.
module ysyx_22040632_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rrst_n,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc2id,
  output logic [31:0] inst2id
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // presenting a request
    S_WAIT = 2'd1,  // live request outstanding
    S_FULL = 2'd2,  // skid holds a word, decode stalled
    S_DROP = 2'd3   // stale request outstanding, discard its response
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } slot_t;

  localparam slot_t BUBBLE = '{pc: 32'd0, inst: 32'd0};

  state_t      state_q, state_d;
  logic [31:0] pc_q, fpc_q;
  slot_t       out_q, sk_q;
  logic        sk_v;

  logic        req_hs;       // request accepted this cycle
  logic        rsp_live;     // response belonging to a live fetch
  logic        busy_after;   // a request remains in flight after this cycle
  slot_t       rsp_slot;

  // Decode the events seen this cycle.
  always_comb begin
    req_hs     = (state_q == S_REQ) && imem_req_ready;
    rsp_live   = (state_q == S_WAIT) && imem_rsp_valid;
    busy_after = ((state_q == S_WAIT) && !imem_rsp_valid) ||
                 ((state_q == S_DROP) && !imem_rsp_valid) ||
                 req_hs;
    rsp_slot   = '{pc: fpc_q, inst: imem_rsp_data};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) state_q <= S_REQ;
    else         state_q <= state_d;
  end

  // FSM next-state logic. A flush overrides every other event.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = busy_after ? S_DROP : S_REQ;
    end else begin
      unique case (state_q)
        S_REQ:  if (req_hs) state_d = S_WAIT;
        S_WAIT: if (imem_rsp_valid) state_d = hold ? S_FULL : S_REQ;
        S_FULL: if (!hold) state_d = S_REQ;
        S_DROP: if (imem_rsp_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  // FSM outputs. These are pure state decodes, so no input reaches the request port.
  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    imem_req_addr  = pc_q;
  end

  // Fetch PC advances on each accepted request. A redirect reloads it word-aligned.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      pc_q  <= RESET_PC;
      fpc_q <= 32'd0;
    end else begin
      if (req_hs) fpc_q <= pc_q;
      if (flush)       pc_q <= {redirect_pc[31:2], 2'b00};
      else if (req_hs) pc_q <= pc_q + 32'd4;
    end
  end

  // Skid buffer captures a live response that arrives while decode is stalled.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      sk_q <= BUBBLE;
      sk_v <= 1'b0;
    end else if (flush) begin
      sk_v <= 1'b0;
    end else if (rsp_live && hold) begin
      sk_q <= rsp_slot;
      sk_v <= 1'b1;
    end else if ((state_q == S_FULL) && !hold) begin
      sk_v <= 1'b0;
    end
  end

  // Fetch/decode register. It freezes under hold, takes new data when
  // there is some, and otherwise loads a bubble.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      out_q <= BUBBLE;
    end else if (flush) begin
      out_q <= BUBBLE;
    end else if (!hold) begin
      if (rsp_live)                     out_q <= rsp_slot;
      else if ((state_q == S_FULL) && sk_v) out_q <= sk_q;
      else                              out_q <= BUBBLE;
    end
  end

  assign pc2id   = out_q.pc;
  assign inst2id = out_q.inst;

endmodule

// File: tb/tb_ysyx_22040632_ifu.sv
// Randomized bench for ysyx_22040632_ifu. A latency-randomized memory
// answers fetches. A transaction-level model predicts the request port
// and the fetch/decode register on every cycle.
module tb_ysyx_22040632_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        hold = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] pc2id, inst2id;

  ysyx_22040632_ifu #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rrst_n(rrst_n), .flush(flush), .redirect_pc(redirect_pc),
    .hold(hold), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pc2id(pc2id), .inst2id(inst2id)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
  endtask

  // memory: in-order responses, each at least one cycle after acceptance
  typedef struct { int due; logic [31:0] data; } mrsp_t;
  mrsp_t mq[$];

  // reference model: next fetch PC, the in-flight fetch, skid queue, decode slot
  logic [31:0] m_pc, m_fpc, m_opc, m_oinst;
  bit          m_busy, m_stale;
  logic [63:0] m_skid[$];
  int          cyc;

  task automatic model_reset();
    m_pc = RST_PC; m_fpc = 0; m_opc = 0; m_oinst = 0;
    m_busy = 0; m_stale = 0; m_skid.delete(); mq.delete();
  endtask

  task automatic check_outputs();
    bit ev;
    ev = !m_busy && (m_skid.size() == 0);
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, ev});
    if (ev) chk("req_addr", imem_req_addr, m_pc);
    chk("pc2id", pc2id, m_opc);
    chk("inst2id", inst2id, m_oinst);
  endtask

  // Pick random inputs for one cycle and advance the model over the coming edge.
  task automatic step();
    bit ev, hs, have;
    logic [63:0] word;
    int k;
    ev = !m_busy && (m_skid.size() == 0);
    hold           = ($urandom_range(99) < 30);
    imem_req_ready = ($urandom_range(99) < 70);
    flush          = ($urandom_range(99) < 7);
    if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFFC | {30'd0, 2'($urandom)};
    else                        redirect_pc = $urandom;
    imem_rsp_valid = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_data  = imem_rsp_valid ? mq[0].data : 32'($urandom);
    if (imem_rsp_valid) void'(mq.pop_front());
    hs = ev && imem_req_ready;
    if (hs) begin
      k = $urandom_range(4, 1);
      mq.push_back('{due: cyc + k, data: $urandom});
    end
    if (flush) begin
      m_busy  = (m_busy && !imem_rsp_valid) || hs;
      m_stale = m_busy;
      m_skid.delete();
      m_opc = 0; m_oinst = 0;
      m_pc = redirect_pc & ~32'd3;
    end else begin
      have = 0; word = 0;
      if (imem_rsp_valid && m_busy) begin
        if (!m_stale) begin have = 1; word = {m_fpc, imem_rsp_data}; end
        m_busy = 0; m_stale = 0;
      end
      if (hold) begin
        if (have) m_skid.push_back(word);
      end else if (have) begin
        {m_opc, m_oinst} = word;
      end else if (m_skid.size() > 0) begin
        {m_opc, m_oinst} = m_skid.pop_front();
      end else begin
        m_opc = 0; m_oinst = 0;
      end
      if (hs) begin
        m_fpc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1; m_stale = 0;
      end
    end
  endtask

  task automatic do_reset();
    rrst_n = 1'b0; flush = 0; hold = 0; imem_req_ready = 0; imem_rsp_valid = 0;
    #1;
    model_reset();
    chk("rst_pc2id", pc2id, 32'd0);
    chk("rst_inst2id", inst2id, 32'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    @(negedge clk);
    rrst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    cyc = 0;
    repeat (2) @(negedge clk);
    do_reset();
    for (int i = 0; i < NCYC; i++) begin
      if (i == NCYC / 2) do_reset();
      check_outputs();
      step();
      @(negedge clk);
      cyc++;
    end
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_22040632_ifu.md
# ysyx_22040632_ifu

Instruction fetch unit for the ysyx_22040632 five-stage RV64 core: owns the program counter, issues word fetches to instruction memory over a valid/ready request plus valid response channel, and drives the fetch/decode pipeline register (`pc2id`, `inst2id`) consumed by the decode stage. It honours decode back-pressure (`hold`) and pipeline redirects (`flush` + `redirect_pc`), discarding in-flight fetches on redirect. Empty pipeline slots are presented as all-zero instructions, which decode treats as nop.

## Interface
- `RESET_PC`, default 32'h8000_0000: first fetch address after reset.
- `clk`  in  1  clock; all state on rising edge.
- `rrst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  redirect request; highest priority.
- `redirect_pc`  in  32  new fetch address when `flush`=1; bits [1:0] ignored and forced to 0.
- `hold`  in  1  decode stall; OR of decode block and `block_id2if`; freezes `pc2id`/`inst2id`.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response data valid; always accepted, one response per accepted request, in order.
- `imem_rsp_data`  in  32  fetched instruction.
- `pc2id`  out  32  PC of instruction in fetch/decode register.
- `inst2id`  out  32  instruction to decode; 0 = bubble.

## Operation
- State: `pc_q` (next fetch address), `fpc_q` (address of outstanding fetch), output register {`pc2id`,`inst2id`}, one-entry skid buffer {`sk_pc`,`sk_inst`,`sk_v`}, FSM.
- FSM states: REQ, WAIT, FULL, DROP. At most one request outstanding.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc_q`. On handshake: `fpc_q`<=`pc_q`, `pc_q`<=`pc_q`+4 (32-bit wrap, 32'hFFFF_FFFC -> 0), -> WAIT.
- WAIT: `imem_req_valid`=0. On `imem_rsp_valid`: if `hold`=0, output register <= {`fpc_q`, data}, -> REQ; if `hold`=1, skid <= {`fpc_q`, data}, `sk_v`=1, -> FULL.
- FULL: no requests. When `hold`=0: output <= skid, `sk_v`<=0, -> REQ.
- DROP: no requests; `imem_rsp_valid` discards data, -> REQ.
- Output register, no `flush`: `hold`=1 -> keep; `hold`=0 and no new data (response or skid) -> load bubble {0,0}.
- `flush` (any state, overrides `hold` and every other event in that cycle): `pc_q`<=`redirect_pc`&~3; output register <= {0,0}; `sk_v`<=0; next state DROP if a request is outstanding after this cycle (WAIT without `imem_rsp_valid`, REQ with handshake, DROP without `imem_rsp_valid`), else REQ. A response arriving in the flush cycle is discarded.
- Reset: `pc_q`=`RESET_PC`, `fpc_q`=0, `pc2id`=0, `inst2id`=0, `sk_v`=0, state REQ; `imem_req_valid`=1 from the first cycle after `rrst_n` rises. Reset mid-fetch abandons the request; memory side is reset together.

## Timing
- `imem_req_valid`/`imem_req_addr` are registered-state decodes (no combinational path from `imem_req_ready`, `flush`, `hold`).
- Request accepted at cycle N, response at N+k (k>=1): instruction on `inst2id` at N+k+1 when `hold`=0 at N+k.
- Zero-wait memory (ready always, k=1): one instruction per 2 cycles (REQ, WAIT alternate).
- `flush` at cycle N: `inst2id`=0 at N+1; first request to `redirect_pc` at N+1 (no outstanding) or one cycle after the pending response drains.
- `hold` released at N with skid valid: skid instruction on `inst2id` at N+1, next request at N+1.
- `imem_req_addr` stable while `imem_req_valid`=1 and `imem_req_ready`=0 unless `flush`.

## Test plan
- Reset release, ready=1, k=1, rsp data 32'h00000013/32'h00100093: `imem_req_addr` 8000_0000 then 8000_0004; `pc2id`/`inst2id` = 8000_0000/00000013 then 8000_0004/00100093, bubbles between.
- `hold`=1 for 5 cycles while response for 8000_0008 arrives: output frozen on previous instruction, skid captures, no request issued; after release `inst2id` = fetched word at next cycle, request to 8000_000C follows.
- `flush` with `redirect_pc`=8000_0103 while WAIT (k=4): `inst2id`=0 next cycle, pending response discarded, next request addr = 8000_0100.
- `flush` coincident with `imem_rsp_valid` and `hold`=1: data dropped, skid empty, output 0, next request to redirect target next cycle.
- Back-to-back `flush` in DROP (targets 8000_0200 then 8000_0300): only 8000_0300 fetched after the single outstanding response.
- `pc_q`=FFFF_FFFC: next request address 0000_0000.
